// File: rtl/servo_cmd_sequencer.sv
// rtl/servo_cmd_sequencer.sv - buffered servo position command sequencer with per-command dwell
module servo_cmd_sequencer #(
    parameter int FIFO_DEPTH   = 4,
    parameter int DWELL_CYCLES = 2_000_000,
    parameter int CNT_W        = 22
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_id,
    input  logic [1:0]                    cmd_pos,
    output logic [1:0]                    pos1,
    output logic [1:0]                    pos2,
    output logic [1:0]                    pos3,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, APPLY, DWELL} state_t;

    state_t            state;
    logic [3:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [3:0]        cmd_q;
    logic [CNT_W-1:0]  dwell_cnt;
    logic              full;
    logic              push;
    logic              pop;

    // Full is taken from the occupancy count so a same-cycle pop never reopens the input.
    assign full      = (level == LW'(FIFO_DEPTH));
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state == IDLE) && (level != '0);
    assign busy      = (state != IDLE) || (level != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_id, cmd_pos};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_q     <= '0;
            dwell_cnt <= '0;
            pos1      <= 2'b00;
            pos2      <= 2'b00;
            pos3      <= 2'b00;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        cmd_q <= mem[rd_ptr];
                        state <= APPLY;
                    end
                end
                APPLY: begin
                    if (cmd_q[1:0] == 2'b11) begin
                        // Illegal code: report and skip the dwell entirely.
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        case (cmd_q[3:2])
                            2'b00: begin
                                pos1 <= cmd_q[1:0];
                                pos2 <= cmd_q[1:0];
                                pos3 <= cmd_q[1:0];
                            end
                            2'b01:   pos1 <= cmd_q[1:0];
                            2'b10:   pos2 <= cmd_q[1:0];
                            default: pos3 <= cmd_q[1:0];
                        endcase
                        dwell_cnt <= '0;
                        state     <= DWELL;
                    end
                end
                DWELL: begin
                    if (dwell_cnt == CNT_W'(DWELL_CYCLES - 1)) begin
                        state <= IDLE;
                    end else begin
                        dwell_cnt <= dwell_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_servo_cmd_sequencer.sv
// tb/tb_servo_cmd_sequencer.sv - scoreboard bench for servo_cmd_sequencer
module tb_servo_cmd_sequencer;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_id = 2'b00;
    logic [1:0] cmd_pos = 2'b00;
    logic       cmd_ready;
    logic [1:0] pos1, pos2, pos3;
    logic       busy;
    logic [2:0] level;
    logic       err;

    servo_cmd_sequencer #(
        .FIFO_DEPTH  (DEPTH),
        .DWELL_CYCLES(DW),
        .CNT_W       (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_id   (cmd_id),
        .cmd_pos  (cmd_pos),
        .pos1     (pos1),
        .pos2     (pos2),
        .pos3     (pos3),
        .busy     (busy),
        .level    (level),
        .err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [1:0] p1;
        logic [1:0] p2;
        logic [1:0] p3;
        bit         is_err;
    } ev_t;

    typedef struct {
        int pop_at;
        int idle_at;
    } pop_t;

    ev_t  evq[$];
    pop_t popq[$];
    int   accepted = 0;
    int   last_idle = 0;
    int   stall_cnt = 0;
    logic [1:0] m1 = 0, m2 = 0, m3 = 0;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference: each accepted command is popped once the queue ahead of it has drained and
    // the sequencer is idle; legal ones occupy DW cycles after the update, illegal ones none.
    task automatic model_accept(input logic [1:0] id, input logic [1:0] p, input int t);
        int   pop_at;
        ev_t  e;
        pop_t q;
        accepted++;
        pop_at = (t + 1 > last_idle + 1) ? t + 1 : last_idle + 1;
        e.at = pop_at + 1;
        if (p == 2'b11) begin
            e.is_err  = 1'b1;
            last_idle = pop_at + 1;
        end else begin
            e.is_err = 1'b0;
            if (id == 2'd0 || id == 2'd1) m1 = p;
            if (id == 2'd0 || id == 2'd2) m2 = p;
            if (id == 2'd0 || id == 2'd3) m3 = p;
            last_idle = pop_at + 1 + DW;
        end
        e.p1 = m1; e.p2 = m2; e.p3 = m3;
        evq.push_back(e);
        q.pop_at  = pop_at;
        q.idle_at = last_idle;
        popq.push_back(q);
    endtask

    int         popped = 0;
    int         cur_idle = 0;
    logic [1:0] c1 = 0, c2 = 0, c3 = 0;
    bit         exp_err;
    int         lvl;
    ev_t        ev;

    always @(negedge clk) begin
        if (!rst_n) begin
            popped = 0; cur_idle = 0;
            c1 = 0; c2 = 0; c3 = 0;
        end else begin
            while (popq.size() > 0 && popq[0].pop_at <= cyc) begin
                popped++;
                cur_idle = popq[0].idle_at;
                void'(popq.pop_front());
            end
            exp_err = 1'b0;
            if (evq.size() > 0 && evq[0].at <= cyc) begin
                ev = evq.pop_front();
                if (ev.is_err) exp_err = 1'b1;
                else begin c1 = ev.p1; c2 = ev.p2; c3 = ev.p3; end
            end
            lvl = accepted - popped;
            chk("level", int'(level), lvl);
            chk("cmd_ready", int'(cmd_ready), int'(lvl < DEPTH));
            chk("busy", int'(busy), int'(lvl != 0 || cyc < cur_idle));
            chk("err", int'(err), int'(exp_err));
            chk("pos1", int'(pos1), int'(c1));
            chk("pos2", int'(pos2), int'(c2));
            chk("pos3", int'(pos3), int'(c3));
        end
    end

    task automatic send(input logic [1:0] id, input logic [1:0] p);
        bit rdy;
        bit done;
        done = 1'b0;
        cmd_valid = 1'b1; cmd_id = id; cmd_pos = p;
        for (int k = 0; k < 200 && !done; k++) begin
            rdy = cmd_ready;
            if (!rdy) stall_cnt++;
            @(posedge clk);
            #1;
            if (rdy) begin
                model_accept(id, p, cyc);
                done = 1'b1;
            end
        end
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        #1;
        chk("rst_pos1", int'(pos1), 0);
        chk("rst_pos2", int'(pos2), 0);
        chk("rst_pos3", int'(pos3), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_busy", int'(busy), 0);
        evq.delete();
        popq.delete();
        accepted = 0;
        m1 = 0; m2 = 0; m3 = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_idle = cyc;
        #1;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
    endtask

    initial begin
        reset_dut();
        // single command, then broadcast followed by servo1 move
        send(2'd2, 2'd2);
        idle(15);
        send(2'd0, 2'd1);
        send(2'd1, 2'd2);
        idle(25);
        // six back-to-back commands overflow the 4-entry FIFO
        stall_cnt = 0;
        for (int i = 0; i < 6; i++) send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)));
        chk("fifo_full_stall", int'(stall_cnt > 0), 1);
        idle(80);
        // illegal command between legal ones
        send(2'd2, 2'd1);
        send(2'd3, 2'd3);
        send(2'd3, 2'd2);
        idle(40);
        // reset in the middle of a dwell with three commands queued
        for (int i = 0; i < 4; i++) send(2'd1 + 2'(i % 3), 2'd1);
        idle(4);
        reset_dut();
        idle(30);
        chk("post_rst_pos1", int'(pos1), 0);
        chk("post_rst_pos2", int'(pos2), 0);
        chk("post_rst_pos3", int'(pos3), 0);
        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 12));
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 1000 && evq.size() > 0; i++) idle(1);
        chk("drain", evq.size(), 0);
        idle(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
